// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader: ping-pong frame buffer feeding the radix-2 butterfly array.
// Accepts samples in natural order and re-emits each frame of 2^LOG2PTS
// samples in bit-reversed index order, one sample per cycle.
// Optional build macro FRAME_CHECK_EN adds in_last / frame_err framing check.
module fft_bitrev_loader #(
    parameter int unsigned N       = 8,
    parameter int unsigned LOG2PTS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_re,
    input  logic [N-1:0]       in_im,
`ifdef FRAME_CHECK_EN
    input  logic               in_last,
    output logic               frame_err,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_re,
    output logic [N-1:0]       out_im,
    output logic [LOG2PTS-1:0] out_idx,
    output logic               out_last
);

    localparam int unsigned P = 1 << LOG2PTS;
    localparam int unsigned W = 2 * N;
    localparam int          LP = int'(LOG2PTS);
    localparam logic [LOG2PTS-1:0] PTR_MAX = LOG2PTS'(P - 1);

    // Mirror the address bits: natural index -> bit-reversed index.
    function automatic logic [LOG2PTS-1:0] bitrev(input logic [LOG2PTS-1:0] a);
        logic [LOG2PTS-1:0] r;
        r = '0;
        for (int i = 0; i < LP; i++) begin
            r[i] = a[LP-1-i];
        end
        return r;
    endfunction

    logic [W-1:0]       mem_q [2][P];
    logic [LOG2PTS-1:0] wptr_q, wptr_d;
    logic [LOG2PTS-1:0] rptr_q, rptr_d;
    logic               wsel_q, wsel_d;
    logic               rsel_q, rsel_d;
    logic [1:0]         bank_full_q, bank_full_d;
    logic               wr_en;
    logic               rd_en;
    logic [LOG2PTS-1:0] rd_addr;
    logic [W-1:0]       rd_word;

    // Pointer / bank bookkeeping for writer and reader; both sides may update bank_full together.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        bank_full_d = bank_full_q;
        in_ready    = !bank_full_q[wsel_q];
        out_valid   = bank_full_q[rsel_q];
        wr_en       = in_valid && in_ready;
        rd_en       = out_valid && out_ready;
        if (wr_en) begin
            if (wptr_q == PTR_MAX) begin
                wptr_d              = '0;
                wsel_d              = !wsel_q;
                bank_full_d[wsel_q] = 1'b1;
            end else begin
                wptr_d = wptr_q + LOG2PTS'(1);
            end
        end
        if (rd_en) begin
            if (rptr_q == PTR_MAX) begin
                rptr_d              = '0;
                rsel_d              = !rsel_q;
                bank_full_d[rsel_q] = 1'b0;
            end else begin
                rptr_d = rptr_q + LOG2PTS'(1);
            end
        end
    end

    // Asynchronous read of the draining bank; data forced to zero while empty.
    always_comb begin
        rd_addr  = bitrev(rptr_q);
        rd_word  = mem_q[rsel_q][rd_addr];
        out_idx  = rd_addr;
        out_re   = out_valid ? rd_word[W-1:N] : '0;
        out_im   = out_valid ? rd_word[N-1:0] : '0;
        out_last = out_valid && (rptr_q == PTR_MAX);
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            bank_full_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            bank_full_q <= bank_full_d;
        end
    end

    // Sample RAM write port; contents are never reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wsel_q][wptr_q] <= {in_re, in_im};
        end
    end

`ifdef FRAME_CHECK_EN
    logic frame_err_q, frame_err_d;

    // Sticky flag: in_last must coincide exactly with the final slot of a frame.
    always_comb begin
        frame_err_d = frame_err_q;
        if (wr_en && (in_last != (wptr_q == PTR_MAX))) begin
            frame_err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Scoreboard bench for fft_bitrev_loader: an input-side model pushes each
// completed frame in bit-reversed order; a monitor pops and compares outputs.
module tb_fft_bitrev_loader;

    typedef struct packed {
        logic [7:0] re;
        logic [7:0] im;
        logic [2:0] idx;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_re;
    logic [7:0] in_im;
    logic       in_last_v;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_re;
    logic [7:0] out_im;
    logic [2:0] out_idx;
    logic       out_last;
`ifdef FRAME_CHECK_EN
    logic       frame_err;
`endif

    fft_bitrev_loader #(.N(8), .LOG2PTS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_re    (in_re),
        .in_im    (in_im),
`ifdef FRAME_CHECK_EN
        .in_last  (in_last_v),
        .frame_err(frame_err),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_idx  (out_idx),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         br[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    exp_t       q[$];
    exp_t       e;
    logic [15:0] fbuf[8];
    int         acc_cnt = 0;
    int         first_acc_cyc = -1;
    int         first_valid_cyc = -1;
    int         run = 0;
    int         max_run = 0;
    int         stalls = 0;
    bit         toggle_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Backpressure pattern generator: flips out_ready every cycle when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) out_ready = ~out_ready;
        end
    end

    // Input-side model plus output monitor, both sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            acc_cnt = 0;
            run = 0;
        end else begin
            if (in_valid && in_ready) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                fbuf[acc_cnt] = {in_re, in_im};
                acc_cnt++;
                if (acc_cnt == 8) begin
                    for (int j = 0; j < 8; j++) begin
                        e.re   = fbuf[br[j]][15:8];
                        e.im   = fbuf[br[j]][7:0];
                        e.idx  = 3'(br[j]);
                        e.last = (j == 7);
                        q.push_back(e);
                    end
                    acc_cnt = 0;
                end
            end
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                run++;
                if (run > max_run) max_run = run;
                if (q.size() == 0) begin
                    chk("out_valid_without_expected", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_re",   32'(out_re),   32'(q[0].re));
                    chk("out_im",   32'(out_im),   32'(q[0].im));
                    chk("out_idx",  32'(out_idx),  32'(q[0].idx));
                    chk("out_last", 32'(out_last), 32'(q[0].last));
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                run = 0;
                chk("idle_outputs_zero", 32'({out_re, out_im, out_last}), 32'd0);
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] re, input logic [7:0] im, input logic last);
        int w;
        w = 0;
        in_valid  = 1'b1;
        in_re     = re;
        in_im     = im;
        in_last_v = last;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            stalls++;
            @(negedge clk);
        end
        if (w >= 100) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last_v = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] base, input int last_pos);
        for (int k = 0; k < 8; k++) begin
            send(base + 8'(k), base + 8'(k) + 8'h10, k == last_pos);
        end
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while ((q.size() != 0 || out_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk(name, 32'(w >= 300), 32'd0);
        sync();
    endtask

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_re = '0; in_im = '0; in_last_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_re",    32'(out_re),    32'd0);
        chk("rst_out_im",    32'(out_im),    32'd0);
        chk("rst_out_idx",   32'(out_idx),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
`ifdef FRAME_CHECK_EN
        chk("rst_frame_err", 32'(frame_err), 32'd0);
`endif
        sync();

        // Ordering: single frame re=k, im=0x10+k, out_ready held high.
        out_ready = 1'b1;
        first_acc_cyc = -1; first_valid_cyc = -1; stalls = 0;
        send_frame(8'h00, 7);
        wait_drain("order_drain");
        chk("order_latency", 32'(first_valid_cyc - first_acc_cyc), 32'd8);
        chk("order_stalls", 32'(stalls), 32'd0);

        // Backpressure: out_ready toggling every cycle.
        toggle_mode = 1'b1;
        send_frame(8'h20, 7);
        wait_drain("backpressure_drain");
        toggle_mode = 1'b0;
        sync();
        out_ready = 1'b1;

        // Full stall: both banks fill, then the writer must block.
        out_ready = 1'b0; stalls = 0;
        send_frame(8'h40, 7);
        send_frame(8'h50, 7);
        chk("full_16_no_stall", 32'(stalls), 32'd0);
        in_valid = 1'b1; in_re = 8'hEE; in_im = 8'hEE;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready_low", 32'(in_ready), 32'd0);
        end
        sync();
        in_valid = 1'b0; out_ready = 1'b1;
        w = 0;
        while (!(out_valid && out_last) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("full_wait_last", 32'(w >= 50), 32'd0);
        chk("in_ready_at_last", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("in_ready_after_last", 32'(in_ready), 32'd1);
        wait_drain("full_drain");

        // Streaming: three back-to-back frames, no bubbles anywhere.
        stalls = 0; max_run = 0; first_acc_cyc = -1; first_valid_cyc = -1;
        send_frame(8'h60, 7);
        send_frame(8'h70, 7);
        send_frame(8'h80, 7);
        wait_drain("stream_drain");
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_contiguous", 32'(max_run), 32'd24);
        chk("stream_latency", 32'(first_valid_cyc - first_acc_cyc), 32'd8);

        // Reset mid-frame: partial frame must vanish.
        for (int k = 0; k < 5; k++) send(8'h90 + 8'(k), 8'hA0 + 8'(k), 1'b0);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        sync();
        send_frame(8'hB0, 7);
        wait_drain("midrst_drain");

`ifdef FRAME_CHECK_EN
        // Framing check: in_last on the 6th sample sets the sticky flag.
        chk("ferr_clear_before", 32'(frame_err), 32'd0);
        for (int k = 0; k < 8; k++) begin
            send(8'hC0 + 8'(k), 8'hD0 + 8'(k), k == 5);
            if (k == 5) chk("ferr_set_next_cycle", 32'(frame_err), 32'd1);
        end
        wait_drain("ferr_drain");
        chk("ferr_sticky", 32'(frame_err), 32'd1);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        chk("ferr_cleared_by_rst", 32'(frame_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
